// File: rtl/collision_checker.sv
// Next-head computation for one snake move (wall or wrap edges) followed by a
// sequential self-collision scan of the body-position RAM.
//
// state | meaning
// IDLE  | waiting for start; captures the move request
// WALL  | computes next head and edge/wall condition, decides scan range
// SCAN  | issues body addresses 1..L, compares each returned segment
// DRAIN | compares the last segment returned after the final address
// DONE  | one-cycle result pulse
module collision_checker #(
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    parameter int COL_BITS = 3,
    parameter int ROW_BITS = 3,
    parameter int ADDR_W   = 6
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ROW_BITS+COL_BITS-1:0] head,
    input  logic [1:0]                   direction,
    input  logic                         wrap_en,
    input  logic                         grow,
    input  logic [ADDR_W:0]              length,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [ROW_BITS+COL_BITS-1:0] mem_data,
    output logic                         busy,
    output logic                         done,
    output logic [ROW_BITS+COL_BITS-1:0] next_head,
    output logic                         collide_wall,
    output logic                         collide_self,
    output logic                         collide
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WALL,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(ROWS - 1);

    state_t state, state_nxt;

    logic [ROW_BITS-1:0] row_q, nxt_row;
    logic [COL_BITS-1:0] col_q, nxt_col;
    logic [1:0]          dir_q;
    logic                wrap_q;
    logic                grow_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     len_eff;
    logic [ADDR_W-1:0]   scan_last;
    logic [ADDR_W-1:0]   cnt_q;
    logic                cmp_en_q;
    logic                bad_pos;
    logic                at_edge;
    logic                wall_hit;
    logic                no_scan;
    logic                match;

    // Edge detection and modulo-COLS/ROWS step of the captured head.
    always_comb begin
        bad_pos = (int'(col_q) >= COLS) || (int'(row_q) >= ROWS);
        at_edge = 1'b0;
        nxt_row = row_q;
        nxt_col = col_q;
        case (dir_q)
            DIR_RIGHT: begin
                at_edge = (col_q == COL_MAX);
                nxt_col = at_edge ? '0 : col_q + COL_BITS'(1);
            end
            DIR_LEFT: begin
                at_edge = (col_q == '0);
                nxt_col = at_edge ? COL_MAX : col_q - COL_BITS'(1);
            end
            DIR_DOWN: begin
                at_edge = (row_q == ROW_MAX);
                nxt_row = at_edge ? '0 : row_q + ROW_BITS'(1);
            end
            DIR_UP: begin
                at_edge = (row_q == '0);
                nxt_row = at_edge ? ROW_MAX : row_q - ROW_BITS'(1);
            end
        endcase
        wall_hit = bad_pos || (at_edge && !wrap_q);
    end

    // The tail segment vacates unless growing, so it drops out of the scan.
    always_comb begin
        len_eff = (len_q == '0) ? (ADDR_W+1)'(1) : len_q;
        if (grow_q) begin
            no_scan   = (len_eff < (ADDR_W+1)'(2));
            scan_last = len_eff[ADDR_W-1:0] - ADDR_W'(1);
        end else begin
            no_scan   = (len_eff < (ADDR_W+1)'(3));
            scan_last = len_eff[ADDR_W-1:0] - ADDR_W'(2);
        end
    end

    assign match = (mem_data == next_head);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_WALL;
                end
            end
            S_WALL: begin
                busy      = 1'b1;
                state_nxt = (wall_hit || no_scan) ? S_DONE : S_SCAN;
            end
            S_SCAN: begin
                busy = 1'b1;
                if (cmp_en_q && match) begin
                    state_nxt = S_DONE;
                end else if (cnt_q == '0) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // cnt_q counts addresses still to be issued after the current one.
    always_ff @(posedge clock) begin
        if (!reset) begin
            row_q        <= '0;
            col_q        <= '0;
            dir_q        <= '0;
            wrap_q       <= 1'b0;
            grow_q       <= 1'b0;
            len_q        <= '0;
            cnt_q        <= '0;
            cmp_en_q     <= 1'b0;
            mem_addr     <= '0;
            next_head    <= '0;
            collide_wall <= 1'b0;
            collide_self <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        {row_q, col_q} <= head;
                        dir_q          <= direction;
                        wrap_q         <= wrap_en;
                        grow_q         <= grow;
                        len_q          <= length;
                    end
                end
                S_WALL: begin
                    collide_self <= 1'b0;
                    collide_wall <= wall_hit;
                    next_head    <= wall_hit ? {row_q, col_q} : {nxt_row, nxt_col};
                    if (!wall_hit && !no_scan) begin
                        mem_addr <= ADDR_W'(1);
                        cnt_q    <= scan_last - ADDR_W'(1);
                        cmp_en_q <= 1'b0;
                    end
                end
                S_SCAN: begin
                    cmp_en_q <= 1'b1;
                    if (cmp_en_q && match) begin
                        collide_self <= 1'b1;
                    end else if (cnt_q != '0) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        cnt_q    <= cnt_q - ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (match) begin
                        collide_self <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign collide = collide_wall | collide_self;

endmodule

// File: tb/tb_collision_checker.sv
// Bench for collision_checker: an 8x8 instance and a 10x6 instance, table
// vectors, corner-case sequences and randomized moves against a reference model.
module tb_collision_checker;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       start_a, start_b;
    logic [2:0] hrow;
    logic [3:0] hcol;
    logic [1:0] dir;
    logic       wrap, grow;
    logic [6:0] len;
    logic [5:0] head_a;
    logic [6:0] head_b;
    logic [5:0] addr_a, mdata_a, nh_a;
    logic [3:0] addr_b;
    logic [6:0] mdata_b, nh_b;
    logic       busy_a, done_a, cw_a, cs_a, c_a;
    logic       busy_b, done_b, cw_b, cs_b, c_b;
    logic [2:0] ram_row [64];
    logic [3:0] ram_col [64];
    int         n_chk = 0;
    int         n_fail = 0;

    assign head_a = {hrow, hcol[2:0]};
    assign head_b = {hrow, hcol};

    always @(posedge clock) begin
        mdata_a <= {ram_row[addr_a], ram_col[addr_a][2:0]};
        mdata_b <= {ram_row[addr_b], ram_col[addr_b]};
    end

    collision_checker dut_a (
        .clock(clock), .reset(reset), .start(start_a), .head(head_a),
        .direction(dir), .wrap_en(wrap), .grow(grow), .length(len),
        .mem_addr(addr_a), .mem_data(mdata_a), .busy(busy_a), .done(done_a),
        .next_head(nh_a), .collide_wall(cw_a), .collide_self(cs_a), .collide(c_a)
    );

    collision_checker #(.COLS(10), .ROWS(6), .COL_BITS(4), .ROW_BITS(3), .ADDR_W(4)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .head(head_b),
        .direction(dir), .wrap_en(wrap), .grow(grow), .length(len[4:0]),
        .mem_addr(addr_b), .mem_data(mdata_b), .busy(busy_b), .done(done_b),
        .next_head(nh_b), .collide_wall(cw_b), .collide_self(cs_b), .collide(c_b)
    );

    typedef struct {
        bit         sel;
        int         r, c;
        logic [1:0] d;
        bit         w, g;
        int         ln;
        int         er, ec;
        bit         ewall, eself;
        int         elat, elast;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: grid arithmetic on plain integers, then a linear body search.
    task automatic model(input bit sel, input int r, input int c, input logic [1:0] d,
                         input bit w, input bit g, input int ln,
                         output int er, output int ec, output bit ewall, output bit eself,
                         output int elat, output int elast);
        int cols, rows, nr, nc, seg_cnt;
        cols  = sel ? 10 : 8;
        rows  = sel ? 6 : 8;
        nr    = r;
        nc    = c;
        ewall = 1'b0;
        eself = 1'b0;
        elast = -1;
        if (c >= cols || r >= rows) begin
            ewall = 1'b1;
        end else begin
            case (d)
                2'd0: nc = c + 1;
                2'd1: nc = c - 1;
                2'd2: nr = r + 1;
                default: nr = r - 1;
            endcase
            if (nc < 0 || nc >= cols || nr < 0 || nr >= rows) begin
                if (w) begin
                    nc = (nc + cols) % cols;
                    nr = (nr + rows) % rows;
                end else begin
                    ewall = 1'b1;
                end
            end
        end
        if (ewall) begin
            er = r; ec = c; elat = 2;
            return;
        end
        er = nr;
        ec = nc;
        seg_cnt = (ln < 1 ? 1 : ln) - (g ? 1 : 2);
        if (seg_cnt < 1) begin
            elat = 2;
            return;
        end
        elat  = seg_cnt + 3;
        elast = seg_cnt;
        for (int k = 1; k <= seg_cnt; k++) begin
            if (int'(ram_row[k]) == er && int'(ram_col[k]) == ec) begin
                eself = 1'b1;
                elat  = k + 3;
                elast = (k + 1 < seg_cnt) ? k + 1 : seg_cnt;
                break;
            end
        end
    endtask

    // One move: start in IDLE, count cycles to done, compare the held result.
    task automatic do_case(input string tag, input bit sel, input int r, input int c,
                           input logic [1:0] d, input bit w, input bit g, input int ln,
                           input bit noise, input bit sid,
                           input int er, input int ec, input bit ewall, input bit eself,
                           input int elat, input int elast);
        int a0, lat;
        bit moved;
        @(negedge clock);
        start_a = 1'b0;
        start_b = 1'b0;
        check({tag, "_idle_busy"}, sel ? busy_b : busy_a, 0);
        check({tag, "_idle_done"}, sel ? done_b : done_a, 0);
        hrow = 3'(r); hcol = 4'(c); dir = d; wrap = w; grow = g; len = 7'(ln);
        a0    = sel ? int'(addr_b) : int'(addr_a);
        moved = 1'b0;
        lat   = -1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clock);
            start_a = 1'b0;
            start_b = 1'b0;
            if ((sel ? int'(addr_b) : int'(addr_a)) != a0) moved = 1'b1;
            if (sel ? done_b : done_a) begin
                lat = cyc;
                break;
            end
            check({tag, "_busy"}, sel ? busy_b : busy_a, 1);
            if (noise) begin
                hrow = 3'($urandom_range(0, 7));
                hcol = 4'($urandom_range(0, 15));
                dir  = 2'($urandom_range(0, 3));
                wrap = 1'($urandom_range(0, 1));
                grow = 1'($urandom_range(0, 1));
                len  = 7'($urandom_range(0, 64));
                if ($urandom_range(0, 1) == 1) begin
                    if (sel) start_b = 1'b1; else start_a = 1'b1;
                end
            end
        end
        if (lat < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: no done within 200 cycles, expected at cycle %0d", tag, elat);
            return;
        end
        if (sid) begin
            if (sel) start_b = 1'b1; else start_a = 1'b1;
        end
        check({tag, "_lat"}, lat, elat);
        check({tag, "_done_busy"}, sel ? busy_b : busy_a, 0);
        check({tag, "_nh_row"}, sel ? nh_b[6:4] : nh_a[5:3], er);
        check({tag, "_nh_col"}, sel ? nh_b[3:0] : {1'b0, nh_a[2:0]}, ec);
        check({tag, "_wall"}, sel ? cw_b : cw_a, ewall);
        check({tag, "_self"}, sel ? cs_b : cs_a, eself);
        check({tag, "_collide"}, sel ? c_b : c_a, ewall | eself);
        if (elast < 0) begin
            check({tag, "_addr_quiet"}, moved, 0);
        end else begin
            check({tag, "_addr_last"}, sel ? addr_b : addr_a, elast);
        end
    endtask

    initial begin
        int seen;
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
        hrow = '0; hcol = '0; dir = '0; wrap = 1'b0; grow = 1'b0; len = 7'd1;
        for (int i = 0; i < 64; i++) begin
            ram_row[i] = 3'd6;
            ram_col[i] = 4'd6;
        end
        repeat (3) @(negedge clock);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_nh", nh_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_wall", cw_a, 0);
        check("rst_self", cs_a, 0);
        check("rst_collide", c_a, 0);
        check("rst_b_busy", busy_b, 0);
        check("rst_b_nh", nh_b, 0);
        check("rst_b_addr", addr_b, 0);
        reset = 1'b1;

        ram_row[1] = 3'd2; ram_col[1] = 4'd1;
        ram_row[2] = 3'd3; ram_col[2] = 4'd1;
        ram_row[3] = 3'd3; ram_col[3] = 4'd2;
        ram_row[4] = 3'd3; ram_col[4] = 4'd3;

        //          sel r  c  d      w  g  ln  er ec  wall self lat last
        tbl[0]  = '{0, 3, 7, 2'd0, 0, 0, 1,  3, 7,  1, 0, 2, -1};
        tbl[1]  = '{0, 0, 4, 2'd3, 1, 0, 1,  7, 4,  0, 0, 2, -1};
        tbl[2]  = '{0, 2, 2, 2'd0, 0, 0, 5,  2, 3,  0, 0, 6,  3};
        tbl[3]  = '{0, 5, 0, 2'd1, 0, 0, 1,  5, 0,  1, 0, 2, -1};
        tbl[4]  = '{0, 7, 3, 2'd2, 0, 1, 9,  7, 3,  1, 0, 2, -1};
        tbl[5]  = '{0, 0, 6, 2'd3, 0, 0, 1,  0, 6,  1, 0, 2, -1};
        tbl[6]  = '{0, 4, 7, 2'd0, 1, 0, 1,  4, 0,  0, 0, 2, -1};
        tbl[7]  = '{0, 1, 0, 2'd1, 1, 1, 0,  1, 7,  0, 0, 2, -1};
        tbl[8]  = '{0, 7, 2, 2'd2, 1, 0, 2,  0, 2,  0, 0, 2, -1};
        tbl[9]  = '{0, 3, 1, 2'd3, 0, 1, 2,  2, 1,  0, 1, 4,  1};
        tbl[10] = '{1, 5, 9, 2'd0, 1, 0, 1,  5, 0,  0, 0, 2, -1};
        tbl[11] = '{1, 5, 9, 2'd2, 0, 0, 1,  5, 9,  1, 0, 2, -1};
        tbl[12] = '{1, 2, 12, 2'd1, 1, 0, 1, 2, 12, 1, 0, 2, -1};
        tbl[13] = '{1, 6, 3, 2'd0, 1, 0, 1,  6, 3,  1, 0, 2, -1};
        tbl[14] = '{1, 0, 3, 2'd3, 1, 0, 1,  5, 3,  0, 0, 2, -1};
        tbl[15] = '{1, 0, 0, 2'd1, 1, 0, 1,  0, 9,  0, 0, 2, -1};
        for (int i = 0; i < 16; i++) begin
            do_case($sformatf("vec%0d", i), tbl[i].sel, tbl[i].r, tbl[i].c, tbl[i].d,
                    tbl[i].w, tbl[i].g, tbl[i].ln, 1'b0, 1'b0, tbl[i].er, tbl[i].ec,
                    tbl[i].ewall, tbl[i].eself, tbl[i].elat, tbl[i].elast);
        end

        // Early exit on segment 2: address 4 onward never issued.
        ram_row[2] = 3'd2; ram_col[2] = 4'd3;
        do_case("early_hit", 0, 2, 2, 2'd0, 0, 0, 5, 1'b0, 1'b0, 2, 3, 0, 1, 5, 3);
        do_case("early_hit_long", 0, 2, 2, 2'd0, 0, 1, 8, 1'b1, 1'b0, 2, 3, 0, 1, 5, 3);
        ram_row[2] = 3'd3; ram_col[2] = 4'd1;

        // Tail rule: the tail only blocks when growing; start during DONE ignored.
        ram_row[5] = 3'd5; ram_col[5] = 4'd4;
        do_case("tail_nogrow", 0, 4, 4, 2'd2, 0, 0, 6, 1'b0, 1'b0, 5, 4, 0, 0, 7, 4);
        do_case("tail_grow", 0, 4, 4, 2'd2, 0, 1, 6, 1'b0, 1'b1, 5, 4, 0, 1, 8, 5);

        // Reset in cycle 3 of a long scan, with a start presented while busy.
        @(negedge clock);
        check("rst_seq_entry_busy", busy_a, 0);
        start_b = 1'b0;
        hrow = 3'd2; hcol = 4'd2; dir = 2'd0; wrap = 1'b0; grow = 1'b1; len = 7'd20;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        @(negedge clock);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        reset   = 1'b0;
        @(negedge clock);
        check("midrst_busy", busy_a, 0);
        check("midrst_done", done_a, 0);
        check("midrst_nh", nh_a, 0);
        check("midrst_addr", addr_a, 0);
        check("midrst_wall", cw_a, 0);
        check("midrst_self", cs_a, 0);
        reset = 1'b1;
        seen  = 0;
        repeat (30) begin
            @(negedge clock);
            if (done_a) seen++;
        end
        check("midrst_no_done", seen, 0);
        do_case("after_rst", 0, 2, 2, 2'd0, 0, 0, 5, 1'b0, 1'b0, 2, 3, 0, 0, 6, 3);

        for (int it = 0; it < 300; it++) begin
            bit         sel, w, g, ewall, eself, noise, sid;
            int         rows, cols, r, c, ln, er, ec, elat, elast, k;
            logic [1:0] d;
            sel   = 1'($urandom_range(0, 1));
            cols  = sel ? 10 : 8;
            rows  = sel ? 6 : 8;
            r     = $urandom_range(0, sel ? 6 : 7);
            c     = $urandom_range(0, sel ? 11 : 7);
            d     = 2'($urandom_range(0, 3));
            w     = 1'($urandom_range(0, 1));
            g     = 1'($urandom_range(0, 1));
            ln    = $urandom_range(0, sel ? 16 : 64);
            noise = 1'($urandom_range(0, 1));
            sid   = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 64; i++) begin
                ram_row[i] = 3'($urandom_range(0, rows - 1));
                ram_col[i] = 4'($urandom_range(0, cols - 1));
            end
            model(sel, r, c, d, w, g, ln, er, ec, ewall, eself, elat, elast);
            if (!ewall && ln >= 3 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(1, ln - 1);
                ram_row[k] = 3'(er);
                ram_col[k] = 4'(ec);
                model(sel, r, c, d, w, g, ln, er, ec, ewall, eself, elat, elast);
            end
            do_case($sformatf("rnd%0d", it), sel, r, c, d, w, g, ln, noise, sid,
                    er, ec, ewall, eself, elat, elast);
        end

        @(negedge clock);
        start_a = 1'b0;
        start_b = 1'b0;
        check("final_idle_a", busy_a, 0);
        check("final_idle_b", busy_b, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
